// File: rtl/sisc_pkg.sv
// sisc_pkg: shared constants for the SISC fetch unit.
// Opcode encodings, status-bit indices, instruction-register field
// positions and the fetch FSM state encoding.
package sisc_pkg;

    // Opcode encodings (IR[31:28])
    localparam logic [3:0] OP_NOOP   = 4'h0;
    localparam logic [3:0] OP_LOD    = 4'h1;
    localparam logic [3:0] OP_STR    = 4'h2;
    localparam logic [3:0] OP_SWP    = 4'h3;
    localparam logic [3:0] OP_BRA    = 4'h4;
    localparam logic [3:0] OP_BRR    = 4'h5;
    localparam logic [3:0] OP_BNE    = 4'h6;
    localparam logic [3:0] OP_BNR    = 4'h7;
    localparam logic [3:0] OP_ALU_OP = 4'h8;
    localparam logic [3:0] OP_HLT    = 4'hF;

    // Status register bit indices {C,V,N,Z}
    localparam int STAT_C = 3;
    localparam int STAT_V = 2;
    localparam int STAT_N = 1;
    localparam int STAT_Z = 0;

    // Instruction register field MSB positions
    localparam int IR_OP_MSB  = 31;
    localparam int IR_MM_MSB  = 27;
    localparam int IR_RD_MSB  = 23;
    localparam int IR_RS_MSB  = 19;
    localparam int IR_RT_MSB  = 15;
    localparam int IR_IMM_MSB = 15;

    // Fetch FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // Absolute-target branches load imm directly; the others are PC-relative
    function automatic logic is_abs_branch(input logic [3:0] op);
        return (op == OP_BRA) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/sisc_fetch_unit_if.sv
// sisc_fetch_unit_if: instruction-memory bus between the fetch unit
// (master) and instruction memory (slave).
interface sisc_fetch_unit_if #(
    parameter int PC_W = 16
);
    logic [PC_W-1:0] imem_addr;
    logic            imem_req;
    logic [31:0]     imem_data;
    logic            imem_ack;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_data,
        input  imem_ack
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_data,
        output imem_ack
    );
endinterface

// File: rtl/sisc_branch_cond.sv
// sisc_branch_cond: decides whether the branch held in IR is taken,
// given its opcode, mask field and the current status register.
module sisc_branch_cond
    import sisc_pkg::*;
(
    input  logic [3:0] i_opcode,
    input  logic [3:0] i_mm,
    input  logic [3:0] i_stat,
    output logic       o_taken
);

    // Branch-taken decision per opcode family
    always_comb begin
        o_taken = 1'b0;
        case (i_opcode)
            OP_BRA, OP_BRR: o_taken = (i_mm == 4'b0000) || ((i_stat & i_mm) != 4'b0000);
            OP_BNE, OP_BNR: o_taken = ((i_stat & i_mm) == 4'b0000);
            default:        o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/sisc_fetch_unit.sv
// sisc_fetch_unit: program counter, instruction register and status
// register for the SISC datapath. Fetches from instruction memory,
// exposes decoded IR fields and applies branches on controller command.
// Optional feature macro: SISC_IMEM_WAIT_EN (variable-latency memory
// with ack handshake and fetch timeout). Without it, memory has a fixed
// one-cycle latency and imem_ack is ignored.
module sisc_fetch_unit
    import sisc_pkg::*;
#(
    parameter int PC_W         = 16,
    parameter int IMEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              ir_load,
    input  logic              pc_write,
    input  logic              br_sel,
    input  logic              stat_en,
    input  logic [3:0]        alu_stat,
    sisc_fetch_unit_if.master imem,
    output logic [3:0]        opcode,
    output logic [3:0]        mm,
    output logic [3:0]        rd,
    output logic [3:0]        rs,
    output logic [3:0]        rt,
    output logic [15:0]       imm,
    output logic [3:0]        stat,
    output logic              fetch_busy,
    output logic              br_taken,
    output logic              halted,
    output logic              fetch_err
);

    fetch_state_t    r_state;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_ir;
    logic [3:0]      r_stat;
    logic            r_req;
    logic            r_busy;
    logic            r_br_taken;
    logic            r_halted;
    logic            r_fetch_err;

    logic            w_taken;
    logic            w_capture;
    logic            w_timeout;
    logic [PC_W-1:0] w_br_target;

`ifdef SISC_IMEM_WAIT_EN
    localparam int TMO_W = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
    logic [TMO_W-1:0] r_wait_cnt;
`else
    logic        w_unused_ack;
    logic [31:0] w_unused_tmo;
    assign w_unused_ack = imem.imem_ack;
    assign w_unused_tmo = 32'(IMEM_TIMEOUT);
`endif

    sisc_branch_cond u_branch_cond (
        .i_opcode (r_ir[IR_OP_MSB -: 4]),
        .i_mm     (r_ir[IR_MM_MSB -: 4]),
        .i_stat   (r_stat),
        .o_taken  (w_taken)
    );

    // Capture / timeout qualification for the word on the memory bus
    always_comb begin
        w_capture = 1'b0;
        w_timeout = 1'b0;
`ifdef SISC_IMEM_WAIT_EN
        if (r_state == ST_WAIT) begin
            w_capture = imem.imem_ack;
            w_timeout = !imem.imem_ack && (r_wait_cnt == TMO_W'(IMEM_TIMEOUT - 1));
        end else begin
            w_capture = 1'b0;
            w_timeout = 1'b0;
        end
`else
        if (r_state == ST_WAIT) begin
            w_capture = 1'b1;
        end else begin
            w_capture = 1'b0;
        end
`endif
    end

    // Branch target: absolute imm or PC-relative with sign-extended imm
    always_comb begin
        w_br_target = r_pc;
        if (is_abs_branch(r_ir[IR_OP_MSB -: 4])) begin
            w_br_target = PC_W'(r_ir[IR_IMM_MSB -: 16]);
        end else begin
            w_br_target = r_pc + PC_W'($signed(r_ir[IR_IMM_MSB -: 16]));
        end
    end

    // Fetch FSM with PC, IR and handshake/status flags as registered outputs
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_ir        <= 32'h0000_0000;
            r_req       <= 1'b0;
            r_busy      <= 1'b0;
            r_br_taken  <= 1'b0;
            r_halted    <= 1'b0;
            r_fetch_err <= 1'b0;
`ifdef SISC_IMEM_WAIT_EN
            r_wait_cnt  <= '0;
`endif
        end else begin
            r_br_taken <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Branch is evaluated only while no fetch is in flight
                    if (pc_write && br_sel && w_taken) begin
                        r_pc       <= w_br_target;
                        r_br_taken <= 1'b1;
                    end
                    if (ir_load) begin
                        r_state <= ST_WAIT;
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
`ifdef SISC_IMEM_WAIT_EN
                        r_wait_cnt <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (w_capture) begin
                        r_ir   <= imem.imem_data;
                        r_pc   <= r_pc + PC_W'(1);
                        r_req  <= 1'b0;
                        r_busy <= 1'b0;
                        if (imem.imem_data[IR_OP_MSB -: 4] == OP_HLT) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_timeout) begin
                        // Dropped fetch: NOOP in IR, PC left where it was
                        r_ir        <= 32'h0000_0000;
                        r_req       <= 1'b0;
                        r_busy      <= 1'b0;
                        r_fetch_err <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
`ifdef SISC_IMEM_WAIT_EN
                        r_wait_cnt <= r_wait_cnt + TMO_W'(1);
`endif
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Status register; a same-cycle branch still sees the previous value
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_stat <= 4'b0000;
        end else if (stat_en) begin
            r_stat <= alu_stat;
        end else begin
            r_stat <= r_stat;
        end
    end

    assign imem.imem_addr = r_pc;
    assign imem.imem_req  = r_req;
    assign opcode         = r_ir[IR_OP_MSB -: 4];
    assign mm             = r_ir[IR_MM_MSB -: 4];
    assign rd             = r_ir[IR_RD_MSB -: 4];
    assign rs             = r_ir[IR_RS_MSB -: 4];
    assign rt             = r_ir[IR_RT_MSB -: 4];
    assign imm            = r_ir[IR_IMM_MSB -: 16];
    assign stat           = r_stat;
    assign fetch_busy     = r_busy;
    assign br_taken       = r_br_taken;
    assign halted         = r_halted;
    assign fetch_err      = r_fetch_err;

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// tb_sisc_fetch_unit: directed-vector bench for sisc_fetch_unit in its
// default (fixed one-cycle memory latency) build.
module tb_sisc_fetch_unit;

    logic        clk;
    logic        rst_f;
    logic        ir_load;
    logic        pc_write;
    logic        br_sel;
    logic        stat_en;
    logic [3:0]  alu_stat;
    logic [3:0]  opcode, mm, rd, rs, rt;
    logic [15:0] imm;
    logic [3:0]  stat;
    logic        fetch_busy, br_taken, halted, fetch_err;

    int n_total = 0;
    int n_bad   = 0;

    sisc_fetch_unit_if #(.PC_W(16)) imem_bus ();

    sisc_fetch_unit #(.PC_W(16), .IMEM_TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .ir_load    (ir_load),
        .pc_write   (pc_write),
        .br_sel     (br_sel),
        .stat_en    (stat_en),
        .alu_stat   (alu_stat),
        .imem       (imem_bus),
        .opcode     (opcode),
        .mm         (mm),
        .rd         (rd),
        .rs         (rs),
        .rt         (rt),
        .imm        (imm),
        .stat       (stat),
        .fetch_busy (fetch_busy),
        .br_taken   (br_taken),
        .halted     (halted),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One fetch of 'word' from address pc_at; optionally assert a branch while busy
    task automatic do_fetch(input logic [31:0] word, input logic [15:0] pc_at,
                            input logic [15:0] pc_next, input logic pw_busy);
        imem_bus.imem_data = word;
        ir_load = 1'b1;
        @(posedge clk); #1;
        ir_load = 1'b0;
        check_val("req_n1",  imem_bus.imem_req, 1'b1);
        check_val("busy_n1", fetch_busy, 1'b1);
        check_val("addr_n1", imem_bus.imem_addr, pc_at);
        if (pw_busy) begin
            pc_write = 1'b1;
            br_sel   = 1'b1;
        end
        @(posedge clk); #1;
        pc_write = 1'b0;
        br_sel   = 1'b0;
        check_val("busy_n2", fetch_busy, 1'b0);
        check_val("req_n2",  imem_bus.imem_req, 1'b0);
        check_val("pc_n2",   imem_bus.imem_addr, pc_next);
        if (pw_busy) check_val("br_busy", br_taken, 1'b0);
    endtask

    // Branch command with optional same-cycle status load
    task automatic do_branch(input logic sel, input logic sten, input logic [3:0] alu,
                             input logic [15:0] exp_pc, input logic exp_taken);
        pc_write = 1'b1;
        br_sel   = sel;
        stat_en  = sten;
        alu_stat = alu;
        @(posedge clk); #1;
        pc_write = 1'b0;
        br_sel   = 1'b0;
        stat_en  = 1'b0;
        check_val("br_taken", br_taken, exp_taken);
        check_val("br_pc",    imem_bus.imem_addr, exp_pc);
        @(posedge clk); #1;
        check_val("br_pulse_end", br_taken, 1'b0);
    endtask

    task automatic set_stat(input logic [3:0] v);
        stat_en  = 1'b1;
        alu_stat = v;
        @(posedge clk); #1;
        stat_en  = 1'b0;
        check_val("stat_load", stat, v);
    endtask

    initial begin
        rst_f = 1'b0; ir_load = 1'b0; pc_write = 1'b0; br_sel = 1'b0;
        stat_en = 1'b0; alu_stat = 4'h0;
        imem_bus.imem_data = 32'h0; imem_bus.imem_ack = 1'b0;
        #12 rst_f = 1'b1;
        @(posedge clk); #1;

        // Reset state
        check_val("rst_pc",     imem_bus.imem_addr, 16'h0000);
        check_val("rst_req",    imem_bus.imem_req, 1'b0);
        check_val("rst_ir",     {opcode, mm, rd, rs, imm}, 32'h0000_0000);
        check_val("rst_stat",   stat, 4'h0);
        check_val("rst_busy",   fetch_busy, 1'b0);
        check_val("rst_br",     br_taken, 1'b0);
        check_val("rst_halted", halted, 1'b0);
        check_val("rst_err",    fetch_err, 1'b0);

        // Decode of an ALU_OP word
        do_fetch(32'h8123_4000, 16'h0000, 16'h0001, 1'b0);
        check_val("dec_op",  opcode, 4'h8);
        check_val("dec_mm",  mm, 4'h1);
        check_val("dec_rd",  rd, 4'h2);
        check_val("dec_rs",  rs, 4'h3);
        check_val("dec_rt",  rt, 4'h4);
        check_val("dec_imm", imm, 16'h4000);

        // BRA mm=Z with Z set: absolute jump
        set_stat(4'b0001);
        do_fetch(32'h4100_0040, 16'h0001, 16'h0002, 1'b0);
        do_branch(1'b1, 1'b0, 4'h0, 16'h0040, 1'b1);

        // BNR mm=Z with Z set: not taken
        do_fetch(32'h7100_FFFE, 16'h0040, 16'h0041, 1'b0);
        do_branch(1'b1, 1'b0, 4'h0, 16'h0041, 1'b0);

        // BRA mm=0 is unconditional; first check br_sel low is ignored
        do_fetch(32'h4000_000F, 16'h0041, 16'h0042, 1'b0);
        do_branch(1'b0, 1'b0, 4'h0, 16'h0042, 1'b0);
        do_branch(1'b1, 1'b0, 4'h0, 16'h000F, 1'b1);

        // BNR with Z clear: 0x0010 + 0xFFFE = 0x000E
        do_fetch(32'h7100_FFFE, 16'h000F, 16'h0010, 1'b0);
        set_stat(4'b0000);
        do_branch(1'b1, 1'b0, 4'h0, 16'h000E, 1'b1);

        // Same-cycle stat_en: branch uses old stat (0) so BNR is taken
        do_fetch(32'h7100_0005, 16'h000E, 16'h000F, 1'b0);
        do_branch(1'b1, 1'b1, 4'b0001, 16'h0014, 1'b1);
        check_val("stat_same_cycle", stat, 4'b0001);

        // pc_write during a fetch is ignored
        do_fetch(32'h4000_FFFE, 16'h0014, 16'h0015, 1'b0);
        do_fetch(32'h0000_0000, 16'h0015, 16'h0016, 1'b1);
        check_val("busy_ir", opcode, 4'h0);

        // BRR +1 from 0xFFFF wraps to 0x0000
        do_fetch(32'h4000_FFFE, 16'h0016, 16'h0017, 1'b0);
        do_branch(1'b1, 1'b0, 4'h0, 16'hFFFE, 1'b1);
        do_fetch(32'h5000_0001, 16'hFFFE, 16'hFFFF, 1'b0);
        do_branch(1'b1, 1'b0, 4'h0, 16'h0000, 1'b1);

        // 0x0002 + 0xFFFD = 0xFFFF, then fetch at 0xFFFF wraps PC to 0
        do_fetch(32'h0000_0000, 16'h0000, 16'h0001, 1'b0);
        do_fetch(32'h5000_FFFD, 16'h0001, 16'h0002, 1'b0);
        do_branch(1'b1, 1'b0, 4'h0, 16'hFFFF, 1'b1);
        do_fetch(32'h0000_0000, 16'hFFFF, 16'h0000, 1'b0);

        // Non-branch opcode in IR: never taken
        do_branch(1'b1, 1'b0, 4'h0, 16'h0000, 1'b0);

        // HLT latches; further ir_load produces no request
        do_fetch(32'hF000_0000, 16'h0000, 16'h0001, 1'b0);
        check_val("hlt_halted", halted, 1'b1);
        check_val("hlt_op",     opcode, 4'hF);
        ir_load = 1'b1;
        @(posedge clk); #1;
        ir_load = 1'b0;
        check_val("hlt_req",  imem_bus.imem_req, 1'b0);
        check_val("hlt_busy", fetch_busy, 1'b0);
        @(posedge clk); #1;
        check_val("hlt_req2", imem_bus.imem_req, 1'b0);
        check_val("hlt_pc",   imem_bus.imem_addr, 16'h0001);

        // Reset out of HALT, load some state, then reset mid-fetch
        rst_f = 1'b0; #2; rst_f = 1'b1;
        @(posedge clk); #1;
        check_val("rst2_halted", halted, 1'b0);
        do_fetch(32'h8123_4000, 16'h0000, 16'h0001, 1'b0);
        set_stat(4'b0101);
        imem_bus.imem_data = 32'h4100_0040;
        ir_load = 1'b1;
        @(posedge clk); #1;
        ir_load = 1'b0;
        check_val("mid_req_before", imem_bus.imem_req, 1'b1);
        rst_f = 1'b0;
        #1;
        check_val("mid_req",    imem_bus.imem_req, 1'b0);
        check_val("mid_busy",   fetch_busy, 1'b0);
        check_val("mid_pc",     imem_bus.imem_addr, 16'h0000);
        check_val("mid_ir",     {opcode, mm, rd, rs, imm}, 32'h0000_0000);
        check_val("mid_stat",   stat, 4'h0);
        // Late ack/data while in reset and after release is ignored
        imem_bus.imem_ack  = 1'b1;
        imem_bus.imem_data = 32'hF000_0000;
        @(posedge clk); #1;
        rst_f = 1'b1;
        @(posedge clk); #1;
        imem_bus.imem_ack = 1'b0;
        check_val("late_op",     opcode, 4'h0);
        check_val("late_req",    imem_bus.imem_req, 1'b0);
        check_val("late_pc",     imem_bus.imem_addr, 16'h0000);
        check_val("late_halted", halted, 1'b0);
        check_val("late_err",    fetch_err, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
